// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : round-robin N-way arbiter for one RAM port, with bounded lock
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
   parameter int N_REQ     = 3,
   parameter int MEM_WIDTH = 65536,
   parameter int LOCK_MAX  = 8,
   localparam int ADDR_W   = $clog2(MEM_WIDTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ-1:0]        lock_i,
   input  logic [N_REQ*4-1:0]      we_i,
   input  logic [N_REQ*ADDR_W-1:0] addr_i,
   input  logic [N_REQ*32-1:0]     wdata_i,
   output logic [N_REQ-1:0]        gnt_o,
   output logic [N_REQ-1:0]        rvalid_o,
   output logic [31:0]             rdata_o,
   output logic                    mem_en_o,
   output logic [3:0]              mem_we_o,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic [31:0]             mem_wdata_o,
   input  logic [31:0]             mem_rdata_i
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);
   localparam logic [IDX_W:0]   N_REQ_C    = (IDX_W+1)'(N_REQ);

   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] rd_idx_q;
   logic             rd_pend_q;
   logic             lock_vld_q;
   logic [IDX_W-1:0] lock_idx_q;
   logic [CNT_W-1:0] lock_cnt_q;

   logic             lock_hit;
   logic             any_req;
   logic             grant;
   logic [IDX_W-1:0] winner;
   logic [IDX_W:0]   scan;
   logic [3:0]       win_we;

   assign lock_hit = lock_vld_q && req_i[lock_idx_q] && (lock_cnt_q < LOCK_MAX_C);

   // Lock holder wins outright; otherwise scan circularly starting after last winner.
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      scan    = '0;
      if (lock_hit) begin
         winner  = lock_idx_q;
         any_req = 1'b1;
      end else begin
         for (int k = 1; k <= N_REQ; k++) begin
            scan = {1'b0, last_q} + (IDX_W+1)'(k);
            if (scan >= N_REQ_C)
               scan = scan - N_REQ_C;
            if (!any_req && req_i[scan[IDX_W-1:0]]) begin
               winner  = scan[IDX_W-1:0];
               any_req = 1'b1;
            end
         end
      end
   end

   assign grant  = any_req && !reset;
   assign win_we = we_i[winner*4 +: 4];

   always_comb begin
      gnt_o       = '0;
      mem_en_o    = 1'b0;
      mem_we_o    = 4'b0;
      mem_addr_o  = '0;
      mem_wdata_o = 32'b0;
      if (grant) begin
         gnt_o[winner] = 1'b1;
         mem_en_o      = 1'b1;
         mem_we_o      = win_we;
         mem_addr_o    = addr_i[winner*ADDR_W +: ADDR_W];
         mem_wdata_o   = wdata_i[winner*32 +: 32];
      end
   end

   // Masked by reset so a read pending when reset arrives is never reported.
   always_comb begin
      rvalid_o = '0;
      if (rd_pend_q && !reset)
         rvalid_o[rd_idx_q] = 1'b1;
   end

   assign rdata_o = mem_rdata_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q     <= IDX_W'(N_REQ - 1);
         rd_pend_q  <= 1'b0;
         rd_idx_q   <= '0;
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
         lock_cnt_q <= '0;
      end else if (grant) begin
         last_q    <= winner;
         rd_pend_q <= (win_we == 4'b0);
         rd_idx_q  <= winner;
         if (lock_i[winner]) begin
            // A holder re-winning after a forced break restarts its hold budget.
            if (lock_hit) begin
               lock_cnt_q <= lock_cnt_q + CNT_W'(1);
            end else begin
               lock_vld_q <= 1'b1;
               lock_idx_q <= winner;
               lock_cnt_q <= CNT_W'(1);
            end
         end else begin
            lock_vld_q <= 1'b0;
            lock_cnt_q <= '0;
         end
      end else begin
         rd_pend_q <= 1'b0;
         if (lock_vld_q && !req_i[lock_idx_q])
            lock_vld_q <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter : directed self-checking bench for ram_port_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

   localparam int N  = 3;
   localparam int MW = 65536;
   localparam int LM = 4;
   localparam int AW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_i;
   logic [N-1:0]    lock_i;
   logic [N*4-1:0]  we_i;
   logic [N*AW-1:0] addr_i;
   logic [N*32-1:0] wdata_i;
   logic [N-1:0]    gnt_o;
   logic [N-1:0]    rvalid_o;
   logic [31:0]     rdata_o;
   logic            mem_en_o;
   logic [3:0]      mem_we_o;
   logic [AW-1:0]   mem_addr_o;
   logic [31:0]     mem_wdata_o;
   logic [31:0]     mem_rdata_i;

   logic [7:0] ram [0:MW-1];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.N_REQ(N), .MEM_WIDTH(MW), .LOCK_MAX(LM)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req_i),
      .lock_i      (lock_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .gnt_o       (gnt_o),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   // Byte-addressed RAM with registered read and per-byte write enables
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o == 4'b0)
            mem_rdata_i <= {ram[mem_addr_o + 16'd3], ram[mem_addr_o + 16'd2],
                            ram[mem_addr_o + 16'd1], ram[mem_addr_o]};
         for (int b = 0; b < 4; b++)
            if (mem_we_o[b]) ram[mem_addr_o + 16'(b)] = mem_wdata_o[b*8 +: 8];
      end
   end

   task automatic preload(input logic [15:0] a, input logic [31:0] w);
      for (int b = 0; b < 4; b++) ram[a + 16'(b)] = w[b*8 +: 8];
   endtask

   task automatic set_port(input int i, input logic [3:0] we, input logic [15:0] a,
                           input logic [31:0] d);
      we_i[i*4 +: 4]     = we;
      addr_i[i*AW +: AW] = a;
      wdata_i[i*32 +: 32] = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset  = 1'b1;
      req_i  = '0;
      lock_i = '0;
      @(negedge clk);
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset  = 1'b1;
      req_i  = 3'b111;
      lock_i = '0;
      set_port(0, 4'b0000, 16'h0004, 32'h1);
      set_port(1, 4'b1111, 16'h0008, 32'h2);
      set_port(2, 4'b0000, 16'h000C, 32'h3);
      #1;
      checks++;
      if (gnt_o !== 3'b000) begin failures++; $display("FAIL rst_gnt got=%b exp=000", gnt_o); end
      checks++;
      if (mem_en_o !== 1'b0 || mem_we_o !== 4'b0 || mem_addr_o !== 16'h0 || mem_wdata_o !== 32'h0) begin
         failures++;
         $display("FAIL rst_mem got en=%b we=%b addr=%h wd=%h exp all zero",
                  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rvalid_o !== 3'b000) begin failures++; $display("FAIL rst_rvalid got=%b exp=000", rvalid_o); end
      reset = 1'b0;
      req_i = '0;
   endtask

   task automatic test_idle();
      @(negedge clk);
      req_i = 3'b000;
      set_port(0, 4'b1111, 16'h1234, 32'hDEADBEEF);
      #1;
      checks++;
      if (gnt_o !== 3'b000 || mem_en_o !== 1'b0 || mem_we_o !== 4'b0 ||
          mem_addr_o !== 16'h0 || mem_wdata_o !== 32'h0) begin
         failures++;
         $display("FAIL idle_port got gnt=%b en=%b we=%b addr=%h wd=%h exp all zero",
                  gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rvalid_o !== 3'b000) begin failures++; $display("FAIL idle_rvalid got=%b exp=000", rvalid_o); end
   endtask

   task automatic test_single_read();
      preload(16'h0010, 32'h12345678);
      @(negedge clk);
      req_i = 3'b001;
      set_port(0, 4'b0000, 16'h0010, 32'h0);
      #1;
      checks++;
      if (gnt_o !== 3'b001) begin failures++; $display("FAIL rd_gnt got=%b exp=001", gnt_o); end
      checks++;
      if (mem_en_o !== 1'b1 || mem_we_o !== 4'b0 || mem_addr_o !== 16'h0010) begin
         failures++;
         $display("FAIL rd_port got en=%b we=%b addr=%h exp en=1 we=0000 addr=0010",
                  mem_en_o, mem_we_o, mem_addr_o);
      end
      @(negedge clk);
      req_i = 3'b000;
      #1;
      checks++;
      if (rvalid_o !== 3'b001) begin failures++; $display("FAIL rd_rvalid got=%b exp=001", rvalid_o); end
      checks++;
      if (rdata_o !== 32'h12345678) begin failures++; $display("FAIL rd_data got=%h exp=12345678", rdata_o); end
   endtask

   task automatic test_round_robin();
      logic [2:0] seq [6];
      seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 3; i++) begin
         preload(16'h0100 + 16'(4*i), 32'hC0DE0000 + 32'(i));
         set_port(i, 4'b0000, 16'h0100 + 16'(4*i), 32'h0);
      end
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         req_i = 3'b111;
         #1;
         checks++;
         if (gnt_o !== seq[c]) begin
            failures++;
            $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, gnt_o, seq[c]);
         end
         if (c > 0) begin
            checks++;
            if (rvalid_o !== seq[c-1]) begin
               failures++;
               $display("FAIL rr_rvalid cycle=%0d got=%b exp=%b", c, rvalid_o, seq[c-1]);
            end
         end
      end
      @(negedge clk);
      req_i = 3'b000;
      #1;
      checks++;
      if (rvalid_o !== 3'b100 || rdata_o !== 32'hC0DE0002) begin
         failures++;
         $display("FAIL rr_last got rvalid=%b rdata=%h exp rvalid=100 rdata=c0de0002", rvalid_o, rdata_o);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      req_i = 3'b010;
      set_port(1, 4'b0100, 16'h0020, 32'h00AB0000);
      #1;
      checks++;
      if (gnt_o !== 3'b010 || mem_we_o !== 4'b0100 || mem_addr_o !== 16'h0020 ||
          mem_wdata_o !== 32'h00AB0000) begin
         failures++;
         $display("FAIL wr_port got gnt=%b we=%b addr=%h wd=%h exp gnt=010 we=0100 addr=0020 wd=00ab0000",
                  gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      @(negedge clk);
      set_port(1, 4'b0000, 16'h0020, 32'h0);
      #1;
      checks++;
      if (rvalid_o !== 3'b000) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=000", rvalid_o); end
      checks++;
      if (gnt_o !== 3'b010) begin failures++; $display("FAIL wr_rd_gnt got=%b exp=010", gnt_o); end
      @(negedge clk);
      req_i = 3'b000;
      #1;
      checks++;
      if (rvalid_o !== 3'b010 || rdata_o !== 32'h00AB0000) begin
         failures++;
         $display("FAIL wr_readback got rvalid=%b rdata=%h exp rvalid=010 rdata=00ab0000", rvalid_o, rdata_o);
      end
   endtask

   task automatic test_lock();
      logic [2:0] seq [8];
      seq = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010, 3'b001};
      set_port(0, 4'b0000, 16'h0040, 32'h0);
      set_port(1, 4'b0000, 16'h0044, 32'h0);
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         req_i  = 3'b011;
         lock_i = (c < 6) ? 3'b010 : 3'b000;
         #1;
         checks++;
         if (gnt_o !== seq[c]) begin
            failures++;
            $display("FAIL lock_gnt cycle=%0d got=%b exp=%b", c, gnt_o, seq[c]);
         end
      end
      @(negedge clk);
      req_i  = 3'b000;
      lock_i = 3'b000;
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      req_i = 3'b001;
      set_port(0, 4'b0000, 16'h0010, 32'h0);
      #1;
      checks++;
      if (gnt_o !== 3'b001) begin failures++; $display("FAIL mid_gnt got=%b exp=001", gnt_o); end
      @(negedge clk);
      reset = 1'b1;
      req_i = 3'b000;
      #1;
      checks++;
      if (rvalid_o !== 3'b000) begin failures++; $display("FAIL mid_rvalid got=%b exp=000", rvalid_o); end
      @(negedge clk);
      reset = 1'b0;
      req_i = 3'b110;
      set_port(1, 4'b0000, 16'h0100, 32'h0);
      set_port(2, 4'b0000, 16'h0104, 32'h0);
      #1;
      checks++;
      if (gnt_o !== 3'b010) begin failures++; $display("FAIL mid_post_gnt got=%b exp=010", gnt_o); end
      checks++;
      if (rvalid_o !== 3'b000) begin failures++; $display("FAIL mid_dropped got=%b exp=000", rvalid_o); end
      @(negedge clk);
      req_i = 3'b000;
      #1;
      checks++;
      if (rvalid_o !== 3'b010) begin failures++; $display("FAIL mid_post_rvalid got=%b exp=010", rvalid_o); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      for (int a = 0; a < MW; a++) ram[a] = 8'h00;
      reset   = 1'b1;
      req_i   = '0;
      lock_i  = '0;
      we_i    = '0;
      addr_i  = '0;
      wdata_i = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_idle();
      test_single_read();
      test_round_robin();
      test_write_read();
      test_lock();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the simulation dual-port byte-addressed RAM (1-cycle registered read, per-byte write enables) among N_REQ requesters, e.g. fetch, LSU and a debug/loader master.
- Round-robin arbitration with zero-latency grant.
- Optional lock, for atomic read-modify-write sequences, with a bounded hold.
- Read data is returned one cycle after grant, tagged to the granted requester.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MEM_WIDTH, 65536, RAM size in bytes; ADDR_W = $clog2(MEM_WIDTH).
- LOCK_MAX, 8, maximum consecutive grants a lock holder keeps before lock is forcibly broken for one arbitration.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  per-requester access request.
- lock_i  in  N_REQ  per-requester lock request, sampled at grant.
- we_i  in  N_REQ*4  per-requester byte write enables; all-zero = read.
- addr_i  in  N_REQ*ADDR_W  per-requester byte address.
- wdata_i  in  N_REQ*32  per-requester write data.
- gnt_o  out  N_REQ  one-hot grant, combinational, same cycle as request.
- rvalid_o  out  N_REQ  one-hot read-data valid.
- rdata_o  out  32  read data, broadcast to all requesters.
- mem_en_o  out  1  RAM port enable.
- mem_we_o  out  4  RAM port byte write enables.
- mem_addr_o  out  ADDR_W  RAM port address.
- mem_wdata_o  out  32  RAM port write data.
- mem_rdata_i  in  32  RAM port read data (valid the cycle after an enabled read).

Behaviour:
- Requester protocol:
  - Requester i holds req_i[i], we, addr and wdata stable until gnt_o[i]=1.
  - A transfer completes in the grant cycle.
  - Requester may re-request the very next cycle.
- Winner selection, evaluated every cycle (combinational):
  - Rule 1 (lock): if lock_vld_q, req_i[lock_idx_q]=1 and lock_cnt_q<LOCK_MAX, winner = lock_idx_q.
  - Rule 2 (round-robin): otherwise winner = first i with req_i[i]=1, scanning circularly from last_q+1.
  - No requests: no winner; gnt_o=0, mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Port drive with a winner: gnt_o[winner]=1; mem_en_o=1; mem_we_o/mem_addr_o/mem_wdata_o = winner's fields.
- Registered state updates, on any grant:
  - last_q <= winner.
  - rd_pend_q <= (we of winner == 0).
  - rd_idx_q <= winner.
- Registered state updates, no grant: rd_pend_q <= 0.
- Read return:
  - rvalid_o = rd_pend_q one-hot at rd_idx_q.
  - rdata_o = mem_rdata_i, passed through combinationally; read latency is exactly 1 cycle after grant.
- Write return: no rvalid; the write takes effect at the grant-cycle clock edge.
- Lock state:
  - Grant with lock_i[winner]=1:
    - If winner==lock_idx_q and lock_vld_q, lock_cnt_q++.
    - Otherwise set lock_vld_q=1, lock_idx_q=winner, lock_cnt_q=1.
  - Grant with lock_i[winner]=0: lock_vld_q<=0, lock_cnt_q<=0.
  - Holder deasserts req_i while lock_vld_q: lock_vld_q<=0.
  - Lock broken by Rule 1 failing (lock_cnt_q==LOCK_MAX): round-robin arbitration applies that cycle.
    - If a different requester wins: lock_vld_q<=0, lock_cnt_q<=0.
    - If the holder wins again (no other requests): lock_cnt_q resets to 1 if lock_i is still set.
- Fairness: without lock, any continuously requesting requester is granted within N_REQ cycles.
- Reset values:
  - last_q=N_REQ-1, so requester 0 has first priority.
  - rd_pend_q=0, rd_idx_q=0, lock_vld_q=0, lock_idx_q=0, lock_cnt_q=0.
- Outputs during reset:
  - gnt_o and all mem_* outputs forced to 0.
  - rvalid_o=0, including on the cycle after reset asserts, so a read pending at reset is dropped.
- Simultaneous events:
  - A read grant in cycle t and a new grant in t+1 overlap legally: rvalid for t is presented alongside the t+1 grant.
  - rdata_o always belongs to the t grant.
- Reads of an address written in the previous cycle return the new data; RAM write-then-read ordering.

Test Plan:
- Single read: req_i=001, addr=0x0010, we=0, RAM[0x10..0x13]=78 56 34 12 -> gnt_o=001 same cycle, mem_en_o=1; next cycle rvalid_o=001, rdata_o=0x12345678.
- Round-robin: req_i=111 held for 6 cycles from reset -> gnt_o sequence 001,010,100,001,010,100; rvalid_o follows one cycle later.
- Byte write then read: requester 1 writes we=0100, addr=0x20, wdata=0x00AB0000; requester 1 then reads 0x20, prior contents 0 -> rdata_o=0x00AB0000, single write grant, no rvalid for the write.
- Lock and break: LOCK_MAX=4, req_i=011 held, lock_i[1]=1 from its first grant -> requester 1 granted 4 consecutive cycles, then requester 0 granted, then lock cleared and round-robin resumes.
- Reset mid-read: read granted at cycle t, reset=1 at t+1 -> rvalid_o=0 at t+1; after reset release with req_i=110, first grant goes to requester 1.
- Idle: req_i=000 -> mem_en_o=0, mem_we_o=0, mem_addr_o=0, gnt_o=0, rvalid_o=0 next cycle.
